// File: rtl/mdu_pkg.sv
// Shared encodings, FSM states and iteration count for the MIPS multiply/divide unit.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op[0] == 1'b0);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op[1] == 1'b1);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/mips_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers (33-cycle latency).
// Define MIPS_MDU_DIV_EN to build the divider; without it, divide requests are ignored.
module mips_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mt_hi,
    input  logic             mt_lo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mdu_pkg::*;

    localparam int            CW       = $clog2(MDU_ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(MDU_ITER - 1);

    state_e               state_r, state_n_s;
    logic [CW-1:0]        cnt_r;
    logic                 busy_r, done_r;
    logic [WIDTH-1:0]     hi_r, lo_r;
    logic                 neg_res_r;
    logic [WIDTH-1:0]     ua_r;
    logic [2*WIDTH-1:0]   acc_r, acc_n_s, prod_s;
    logic [WIDTH:0]       mul_sum_s;
    logic                 a_neg_s, b_neg_s, accept_s;
    logic [WIDTH-1:0]     ua_s, ub_s;
    logic [WIDTH-1:0]     res_hi_s, res_lo_s;

`ifdef MIPS_MDU_DIV_EN
    logic                 op_div_r, neg_rem_r, bzero_r;
    logic [WIDTH-1:0]     ub_r, a_r, rem_r, rem_n_s, quo_n_s, quo_fix_s, rem_fix_s;
    logic [WIDTH:0]       shift_s, trial_s;
`endif

    assign a_neg_s = op_is_signed(op) & a[WIDTH-1];
    assign b_neg_s = op_is_signed(op) & b[WIDTH-1];

`ifdef MIPS_MDU_DIV_EN
    assign accept_s = (state_r == S_IDLE) & start;
`else
    assign accept_s = (state_r == S_IDLE) & start & ~op_is_div(op);
`endif

    mdu_sign_fix #(.WIDTH(WIDTH))   u_abs_a    (.neg(a_neg_s),   .din(a),     .dout(ua_s));
    mdu_sign_fix #(.WIDTH(WIDTH))   u_abs_b    (.neg(b_neg_s),   .din(b),     .dout(ub_s));
    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_res_r), .din(acc_r), .dout(prod_s));
`ifdef MIPS_MDU_DIV_EN
    mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_quo  (.neg(neg_res_r), .din(acc_r[WIDTH-1:0]), .dout(quo_fix_s));
    mdu_sign_fix #(.WIDTH(WIDTH))   u_fix_rem  (.neg(neg_rem_r), .din(rem_r),            .dout(rem_fix_s));
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_n_s = S_CALC;
                else          state_n_s = S_IDLE;
            end
            S_CALC: begin
                if (cnt_r == CNT_LAST) state_n_s = S_FIX;
                else                   state_n_s = S_CALC;
            end
            S_FIX:   state_n_s = S_IDLE;
            default: state_n_s = S_IDLE;
        endcase
    end

    // One shift-add or restoring-divide step; the low accumulator half carries multiplier/quotient bits
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, ua_r} : {(WIDTH+1){1'b0}});
        acc_n_s   = {mul_sum_s, acc_r[WIDTH-1:1]};
`ifdef MIPS_MDU_DIV_EN
        shift_s = {rem_r, acc_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, ub_r};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_n_s = trial_s[WIDTH-1:0];
            quo_n_s = {acc_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_n_s = shift_s[WIDTH-1:0];
            quo_n_s = {acc_r[WIDTH-2:0], 1'b0};
        end
        if (op_div_r) acc_n_s = {acc_r[2*WIDTH-1:WIDTH], quo_n_s};
        else          acc_n_s = {mul_sum_s, acc_r[WIDTH-1:1]};
`endif
    end

    // Final HI/LO selection; divide-by-zero bypasses sign correction entirely
    always_comb begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
`ifdef MIPS_MDU_DIV_EN
        if (op_div_r) begin
            if (bzero_r) begin
                res_hi_s = a_r;
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_hi_s = rem_fix_s;
                res_lo_s = quo_fix_s;
            end
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            neg_res_r <= 1'b0;
            ua_r      <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
`ifdef MIPS_MDU_DIV_EN
            op_div_r  <= 1'b0;
            neg_rem_r <= 1'b0;
            bzero_r   <= 1'b0;
            ub_r      <= {WIDTH{1'b0}};
            a_r       <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        busy_r    <= 1'b1;
                        cnt_r     <= {CW{1'b0}};
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        ua_r      <= ua_s;
                        acc_r     <= {{WIDTH{1'b0}}, ub_s};
`ifdef MIPS_MDU_DIV_EN
                        op_div_r  <= op_is_div(op);
                        neg_rem_r <= a_neg_s;
                        bzero_r   <= (b == {WIDTH{1'b0}});
                        ub_r      <= ub_s;
                        a_r       <= a;
                        rem_r     <= {WIDTH{1'b0}};
                        if (op_is_div(op)) acc_r <= {{WIDTH{1'b0}}, ua_s};
`endif
                    end else begin
                        if (mt_hi) hi_r <= mt_data;
                        if (mt_lo) lo_r <= mt_data;
                    end
                end
                S_CALC: begin
                    cnt_r <= cnt_r + CW'(1);
                    acc_r <= acc_n_s;
`ifdef MIPS_MDU_DIV_EN
                    if (op_div_r) rem_r <= rem_n_s;
`endif
                end
                S_FIX: begin
                    hi_r   <= res_hi_s;
                    lo_r   <= res_lo_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed self-checking bench for mips_mdu: arithmetic results, timing, MTHI/MTLO priority and reset.
module tb_mips_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, mt_hi, mt_lo, busy, done;
    logic [1:0]  op;
    logic [31:0] a, b, mt_data, hi, lo;
    logic [31:0] cur_hi, cur_lo;
    int          vectors = 0;
    int          errors  = 0;

`ifdef MIPS_MDU_DIV_EN
    localparam logic [1:0] RST_OP = OP_DIV;
`else
    localparam logic [1:0] RST_OP = OP_MULTU;
`endif

    mips_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic inject, input logic with_lo);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        mt_lo = with_lo; mt_data = 32'h0000ABCD;
        @(negedge clk);
        start = 1'b0; mt_lo = 1'b0; mt_data = 32'h00001234;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (with_lo && cyc == 1) check("lo_held_start_beats_mtlo", lo, cur_lo);
            if (inject && cyc == 8)  check("hi_held_mthi_while_busy", hi, cur_hi);
            start = inject && (cyc == 5);
            mt_hi = inject && (cyc == 7);
            if (inject && cyc == 5) a = 32'h00000999;
            @(negedge clk);
        end
        start = 1'b0; mt_hi = 1'b0;
        check("busy_cycles", cyc, 32'd33);
        check("done_pulse", {31'b0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    task automatic do_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [1:0] o, input logic [31:0] ehi, input logic [31:0] elo);
`ifdef MIPS_MDU_DIV_EN
        run_op(o, x, y, 1'b0, 1'b0);
        cur_hi = ehi; cur_lo = elo;
`else
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_ignored_busy"}, {31'b0, busy}, 32'd0);
        repeat (34) @(negedge clk);
        check({tag, "_ignored_done"}, {31'b0, done}, 32'd0);
`endif
        check({tag, "_hi"}, hi, cur_hi);
        check({tag, "_lo"}, lo, cur_lo);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
        op = 2'b00; a = 32'h0; b = 32'h0; mt_data = 32'h0;
        cur_hi = 32'h0; cur_lo = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst = 1'b0;

        run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0);
        cur_hi = 32'hFFFFFFFF; cur_lo = 32'hFFFFFFEB;
        check("mult_hi", hi, cur_hi);
        check("mult_lo", lo, cur_lo);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        cur_hi = 32'hFFFFFFFE; cur_lo = 32'h00000001;
        check("multu_hi", hi, cur_hi);
        check("multu_lo", lo, cur_lo);

        do_div("div_neg",  32'hFFFFFFF9, 32'd2,        OP_DIV,  32'hFFFFFFFF, 32'hFFFFFFFD);
        do_div("divu_by0", 32'd100,      32'd0,        OP_DIVU, 32'd100,      32'hFFFFFFFF);
        do_div("div_ovf",  32'h80000000, 32'hFFFFFFFF, OP_DIV,  32'h00000000, 32'h80000000);

        run_op(OP_MULTU, 32'd5, 32'd6, 1'b1, 1'b0);
        cur_hi = 32'h0; cur_lo = 32'd30;
        check("inject_hi", hi, cur_hi);
        check("inject_lo", lo, cur_lo);

        @(negedge clk);
        mt_hi = 1'b1; mt_data = 32'h00001234;
        @(negedge clk);
        mt_hi = 1'b0;
        check("mthi_hi", hi, 32'h00001234);
        check("mthi_lo_kept", lo, 32'd30);
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h00005678;
        @(negedge clk);
        mt_hi = 1'b0; mt_lo = 1'b0;
        cur_hi = 32'h00005678; cur_lo = 32'h00005678;
        check("mtboth_hi", hi, cur_hi);
        check("mtboth_lo", lo, cur_lo);

        run_op(OP_MULTU, 32'd2, 32'd3, 1'b0, 1'b1);
        cur_hi = 32'h0; cur_lo = 32'd6;
        check("start_mtlo_hi", hi, cur_hi);
        check("start_mtlo_lo", lo, cur_lo);

        @(negedge clk);
        start = 1'b1; op = RST_OP; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_rst", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cur_hi = 32'h0; cur_lo = 32'h0;

        run_op(OP_MULT, 32'd3, 32'd4, 1'b0, 1'b0);
        check("post_rst_hi", hi, 32'h0);
        check("post_rst_lo", lo, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
